// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, the add-3 correction threshold and the
// active-low seven-segment lookup ({g,f,e,d,c,b,a}).
package bcd_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CONV = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Digits at or above this value get +3 before each shift (double dabble).
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    // Active-low segment patterns, index = digit value.
    localparam logic [9:0][6:0] SEG_LUT = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Non-decimal codes never occur, but blank them rather than index out of range.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        if (digit <= 4'd9) begin
            return SEG_LUT[digit];
        end
        return 7'b1111111;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Conditional +3 correction.
    always_comb begin
        dout = din;
        if (din >= ADD3_THRESH) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential (one bit per cycle) binary-to-BCD converter.
// Optional seven-segment output stage enabled by defining BCD_SEVSEG_EN.
// Timeline: accept edge, then IN_W shift cycles plus one load cycle in CONV,
// then one DONE cycle with done high; done appears IN_W+1 edges after accept.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned IN_W   = 9,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done
`ifdef BCD_SEVSEG_EN
    ,
    output logic [7*DIGITS-1:0]   seg
`endif
);

    localparam int unsigned CNT_W = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W);

    state_t                state;
    logic [IN_W-1:0]       shreg;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   corr;
    logic [CNT_W-1:0]      cnt;
    logic                  load_result;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch[4*i +: 4]),
            .dout (corr[4*i +: 4])
        );
    end

    // All shift steps done; the scratch now holds the final result.
    assign load_result = (state == ST_CONV) && (cnt == CNT_LAST);

    // FSM, shift register, scratch digits and result register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg   <= bin;
                        scratch <= '0;
                        cnt     <= '0;
                        state   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (load_result) begin
                        bcd   <= scratch;
                        state <= ST_DONE;
                    end else begin
                        scratch <= {corr[4*DIGITS-2:0], shreg[IN_W-1]};
                        shreg   <= {shreg[IN_W-2:0], 1'b0};
                        cnt     <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

`ifdef BCD_SEVSEG_EN
    logic [7*DIGITS-1:0] seg_next;

    // Decode the final scratch so seg changes on the same edge as bcd.
    always_comb begin
        seg_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            seg_next[7*i +: 7] = seg_decode(scratch[4*i +: 4]);
        end
    end

    // Registered segment outputs, blank after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            seg <= '1;
        end else if (load_result) begin
            seg <= seg_next;
        end
    end
`endif

endmodule
